// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - raw button pins in; debounced level and edge pulses out
interface button_debounce_if #(
    parameter int width_p = 3
) ();
    logic [width_p-1:0] btn_async_unsafe_i;
    logic [width_p-1:0] btn_o;
    logic [width_p-1:0] press_o;
    logic [width_p-1:0] release_o;

    modport master (
        output btn_async_unsafe_i,
        input  btn_o,
        input  press_o,
        input  release_o
    );

    modport slave (
        input  btn_async_unsafe_i,
        output btn_o,
        output press_o,
        output release_o
    );
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-bit two-flop synchronizer, stability-counter debounce, press/release pulses
module button_debounce #(
    parameter int width_p         = 3,
    parameter int stable_cycles_p = 120000,
    parameter int active_low_p    = 0
) (
    input logic              clk_i,
    input logic              reset_n_i,
    button_debounce_if.slave btn_if
);
    localparam int cnt_w_lp = (stable_cycles_p < 2) ? 1 : $clog2(stable_cycles_p);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(stable_cycles_p - 1);

    generate
        if (stable_cycles_p < 2) begin : g_bad_stable_cycles
            $error("button_debounce: stable_cycles_p must be at least 2");
        end
    endgenerate

    logic [width_p-1:0]  s1_q, s1_d;
    logic [width_p-1:0]  s2_q, s2_d;
    logic [width_p-1:0]  lvl_q, lvl_d;
    logic [width_p-1:0]  press_q, press_d;
    logic [width_p-1:0]  release_q, release_d;
    logic [cnt_w_lp-1:0] cnt_q [width_p];
    logic [cnt_w_lp-1:0] cnt_d [width_p];
    logic [width_p-1:0]  sample;

    always_comb begin
        s1_d      = btn_if.btn_async_unsafe_i;
        s2_d      = s1_q;
        sample    = (active_low_p != 0) ? ~s2_q : s2_q;
        lvl_d     = lvl_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < width_p; i++) begin
            cnt_d[i] = '0;
            // Any sample agreeing with the current level leaves the count at zero.
            if (sample[i] != lvl_q[i]) begin
                if (cnt_q[i] == cnt_max_lp) begin
                    lvl_d[i]     = sample[i];
                    press_d[i]   = sample[i];
                    release_d[i] = ~sample[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + cnt_w_lp'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_q      <= '0;
            s2_q      <= '0;
            lvl_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < width_p; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            lvl_q     <= lvl_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < width_p; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_if.btn_o     = lvl_q;
    assign btn_if.press_o   = press_q;
    assign btn_if.release_o = release_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed bench for button_debounce with a history-based debounce model
module tb_button_debounce;
    localparam int W = 3;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    button_debounce_if #(.width_p(W)) a_if ();
    button_debounce_if #(.width_p(W)) b_if ();

    button_debounce #(.width_p(W), .stable_cycles_p(N), .active_low_p(0)) dut_a (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .btn_if    (a_if)
    );

    button_debounce #(.width_p(W), .stable_cycles_p(N), .active_low_p(1)) dut_b (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .btn_if    (b_if)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] bt(input int k);
        return (k == 0) ? a_if.btn_o : b_if.btn_o;
    endfunction
    function automatic logic [W-1:0] pr(input int k);
        return (k == 0) ? a_if.press_o : b_if.press_o;
    endfunction
    function automatic logic [W-1:0] rl(input int k);
        return (k == 0) ? a_if.release_o : b_if.release_o;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the level flips once the last N synchronized samples all disagree with it.
    logic [W-1:0] m_s1 [2];
    logic [W-1:0] m_s2 [2];
    logic [W-1:0] m_lvl [2];
    logic [W-1:0] m_prs [2];
    logic [W-1:0] m_rel [2];
    bit   [N-1:0] m_hist [2][W];
    int           m_hcnt [2][W];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_s1[k] = '0; m_s2[k] = '0; m_lvl[k] = '0; m_prs[k] = '0; m_rel[k] = '0;
                for (int i = 0; i < W; i++) begin
                    m_hist[k][i] = '0;
                    m_hcnt[k][i] = 0;
                end
            end else begin
                logic [W-1:0] smp;
                smp = (k == 1) ? ~m_s2[k] : m_s2[k];
                m_prs[k] = '0;
                m_rel[k] = '0;
                for (int i = 0; i < W; i++) begin
                    m_hist[k][i] = {m_hist[k][i][N-2:0], smp[i]};
                    if (m_hcnt[k][i] < N) m_hcnt[k][i]++;
                    if (m_hcnt[k][i] == N && m_hist[k][i] == (m_lvl[k][i] ? {N{1'b0}} : {N{1'b1}})) begin
                        m_lvl[k][i] = ~m_lvl[k][i];
                        m_prs[k][i] = m_lvl[k][i];
                        m_rel[k][i] = ~m_lvl[k][i];
                        m_hcnt[k][i] = 0;
                    end
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = (k == 0) ? a_if.btn_async_unsafe_i : b_if.btn_async_unsafe_i;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("model_btn%0d", k), bt(k), m_lvl[k]);
                check($sformatf("model_press%0d", k), pr(k), m_prs[k]);
                check($sformatf("model_release%0d", k), rl(k), m_rel[k]);
                check($sformatf("excl%0d", k), pr(k) & rl(k), '0);
            end
        end
    end

    task automatic watch(input int k, input int e_pulse, input logic [W-1:0] ep, input logic [W-1:0] er,
                         input logic [W-1:0] eb_before, input logic [W-1:0] eb_after, input string nm);
        for (int e = 1; e <= e_pulse + 1; e++) begin
            @(negedge clk);
            check({nm, "_press"}, pr(k), (e == e_pulse) ? ep : '0);
            check({nm, "_release"}, rl(k), (e == e_pulse) ? er : '0);
            if (e == e_pulse - 1) check({nm, "_btn_before"}, bt(k), eb_before);
            if (e == e_pulse) check({nm, "_btn_after"}, bt(k), eb_after);
        end
    endtask

    initial begin
        a_if.btn_async_unsafe_i = 3'b000;
        b_if.btn_async_unsafe_i = 3'b111;
        #2 rst_n = 1'b0;
        #1;
        check("reset_btn_a", a_if.btn_o, 3'b000);
        check("reset_press_a", a_if.press_o, 3'b000);
        check("reset_release_a", a_if.release_o, 3'b000);
        check("reset_btn_b", b_if.btn_o, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        a_if.btn_async_unsafe_i = 3'b001;
        watch(0, 6, 3'b001, 3'b000, 3'b000, 3'b001, "clean");
        a_if.btn_async_unsafe_i = 3'b000;
        watch(0, 6, 3'b000, 3'b001, 3'b001, 3'b000, "rel0");

        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                a_if.btn_async_unsafe_i = (j == 3) ? 3'b000 : 3'b010;
                @(negedge clk);
            end
        end
        check("bounce_no_rise", a_if.btn_o, 3'b000);
        a_if.btn_async_unsafe_i = 3'b010;
        watch(0, 6, 3'b010, 3'b000, 3'b000, 3'b010, "bounce_hold");

        a_if.btn_async_unsafe_i = 3'b110;
        watch(0, 6, 3'b100, 3'b000, 3'b010, 3'b110, "b2_up");
        a_if.btn_async_unsafe_i = 3'b010;
        repeat (3) @(negedge clk);
        a_if.btn_async_unsafe_i = 3'b110;
        repeat (8) @(negedge clk);
        check("glitch_hold", a_if.btn_o, 3'b110);
        a_if.btn_async_unsafe_i = 3'b010;
        watch(0, 6, 3'b000, 3'b100, 3'b110, 3'b010, "b2_drop");

        a_if.btn_async_unsafe_i = 3'b000;
        repeat (8) @(negedge clk);
        a_if.btn_async_unsafe_i = 3'b111;
        watch(0, 6, 3'b111, 3'b000, 3'b000, 3'b111, "simul");

        a_if.btn_async_unsafe_i = 3'b010;
        repeat (8) @(negedge clk);
        check("pre_reset_level", a_if.btn_o, 3'b010);
        a_if.btn_async_unsafe_i = 3'b011;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_btn", a_if.btn_o, 3'b000);
        check("midreset_press", a_if.press_o, 3'b000);
        check("midreset_release", a_if.release_o, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        watch(0, 6, 3'b011, 3'b000, 3'b000, 3'b011, "after_reset");

        b_if.btn_async_unsafe_i = 3'b110;
        watch(1, 6, 3'b001, 3'b000, 3'b000, 3'b001, "active_low");
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
Conditions the raw mechanical push-buttons of the iCEBreaker board before any logic uses them. Each button input is asynchronous and bouncy. This block synchronizes every bit into the clock domain, filters bounce with a per-bit stability counter, and produces three outputs per button: a clean debounced level, a one-cycle press pulse, and a one-cycle release pulse. It sits directly downstream of the board pins and upstream of all user logic in the top level.

Parameters:
width_p, 3, number of independent button inputs.
stable_cycles_p, 120000, consecutive synchronized samples that must disagree with the current debounced level before the level flips (10 ms at 12 MHz). Legal minimum is 2; any smaller value is a compile-time error.
active_low_p, 0, when 1 each input is inverted after synchronization, so "pressed" always reads as 1 internally.

Ports:
clk_i  input  1  system clock (12 MHz on board).
reset_n_i  input  1  asynchronous, active-low reset.
btn_async_unsafe_i  input  width_p  raw button pins; asynchronous and not de-bounced.
btn_o  output  width_p  debounced level; 1 = pressed.
press_o  output  width_p  one-cycle pulse on each debounced 0->1 transition.
release_o  output  width_p  one-cycle pulse on each debounced 1->0 transition.

Behaviour:
- Reset: reset_n_i low immediately clears the following, regardless of clk_i:
  - both synchronizer flops,
  - all counters,
  - btn_o, press_o and release_o (all 0).
  - Reset is applied asynchronously; the caller supplies a deassertion already synchronized to clk_i.
- Synchronizer: two flops per bit (s1, s2), both reset to 0. The inversion for active_low_p is applied after s2 and is called "sample".
- Per-bit filter (each bit fully independent):
  - Counter width is clog2(stable_cycles_p).
  - Each rising edge, if sample == btn_o: counter <= 0.
  - Otherwise, if counter == stable_cycles_p-1: btn_o <= sample and counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any single sample equal to btn_o restarts the count; the count is never decremented.
- Latency: the raw input is first captured by s1 at edge 1 and changes must hold cleanly. btn_o changes on edge stable_cycles_p+2, counted from edge 1.
- Pulses:
  - press_o[i] is registered and is high for exactly the one cycle in which btn_o[i] first reads 1.
  - release_o[i] is the same for the cycle in which btn_o[i] first reads 0.
  - press_o and release_o are never high together for the same bit.
  - press_o never fires twice without an intervening release_o.
- Equivalent per-bit state view:
  - IDLE_LO (btn_o=0, counter=0). Goes to CNT_HI when sample=1.
  - CNT_HI. Goes back to IDLE_LO on sample=0. Goes to IDLE_HI, with press_o pulsing, when the count completes.
  - IDLE_HI. Goes to CNT_LO when sample=0.
  - CNT_LO. Goes back to IDLE_HI on sample=1. Goes to IDLE_LO, with release_o pulsing, when the count completes.
- Simultaneous events: several bits may flip or pulse in the same cycle; bits never interact.
- Counter never exceeds stable_cycles_p-1; no wrap-around.
- Reset mid-count: all progress is lost. A held button after reset release produces press_o exactly stable_cycles_p+2 edges after the first post-reset edge.
- Inputs held constant: outputs are static, with no spurious pulses.

Test Plan:
All scenarios use stable_cycles_p=4, width_p=3, active_low_p=0.
- Clean press: raise bit0 before edge 1 and hold. Required: btn_o=3'b001 and press_o=3'b001 after edge 6; press_o=0 after edge 7; release_o stays 0.
- Bounce: bit1 toggles 1,1,1,0 repeatedly on successive sampled cycles. Required: btn_o[1] never rises and press_o[1] never pulses. Then hold at 1: press_o[1] pulses exactly 6 edges after the hold begins.
- Release with glitch: start with bit2 debounced high. Drop it for 3 cycles, then back to 1 → btn_o[2] stays 1 with no release. Drop it and hold → release_o[2] pulses once, 6 edges later.
- Simultaneous: raise all bits on the same edge. Required: press_o=3'b111 for exactly one cycle at edge 6.
- Reset mid-count: raise bit0 and assert reset_n_i=0 after edge 4. Required: outputs 0 immediately, with no clock needed. Release reset with bit0 still high: press_o[0] pulses at the 6th subsequent edge.
- active_low_p=1: inputs idle at 3'b111. Required: no pulses after reset. Pull bit0 to 0: press_o[0] pulses after 6 edges.
